// File: rtl/iot_pkg.sv
// iot_pkg: shared constants and types for the IoT result serializer
package iot_pkg;
  localparam int DW_DEF = 128;
  localparam int BW_DEF = 8;
  localparam logic [4:0] HDR_SYNC = 5'b10100;
  localparam logic [2:0] FN_MAX = 3'd1;
  localparam logic [2:0] FN_MIN = 3'd2;
  localparam logic [2:0] FN_AVG = 3'd3;
  localparam logic [2:0] FN_SUM = 3'd4;
  localparam logic [2:0] FN_THRESH = 3'd5;
  localparam logic [2:0] FN_PEAK = 3'd6;
  localparam logic [2:0] FN_PEAKMIN = 3'd7;
  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;
endpackage

// File: rtl/iot_result_serializer_if.sv
// iot_result_serializer_if: byte-wide valid/ready frame link
interface iot_result_serializer_if #(parameter int BW = 8);
  logic out_valid;
  logic [BW-1:0] out_data;
  logic out_last;
  logic out_ready;
  modport master(output out_valid, out_data, out_last, input out_ready);
  modport slave(input out_valid, out_data, out_last, output out_ready);
endinterface

// File: rtl/iot_sync_fifo.sv
// iot_sync_fifo: synchronous FIFO; push and pop in one cycle both honoured, also when full
module iot_sync_fifo #(
  parameter int W = 131,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] cnt
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic do_push, do_pop;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rptr];
  // pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt <= '0;
    end else begin
      wptr <= wptr + AW'(do_push);
      rptr <= rptr + AW'(do_pop);
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  // storage array, contents need no reset
  always_ff @(posedge clk)
    if (do_push) mem[wptr] <= din;
endmodule

// File: rtl/iot_result_serializer.sv
// iot_result_serializer: buffers filter results and emits 17-byte header+data frames
module iot_result_serializer
  import iot_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW = DW_DEF,
  parameter int BW = BW_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic res_valid,
  input  logic [DW-1:0] res_data,
  input  logic [2:0] fn_sel,
  iot_result_serializer_if.master link,
  output logic overflow,
  output logic [$clog2(DEPTH):0] fifo_cnt
);
  localparam int NB = DW / BW;
  localparam int CW = $clog2(NB);
  state_t state, state_n;
  logic [DW-1:0] shreg, shreg_n;
  logic [CW-1:0] bcnt, bcnt_n;
  logic [BW-1:0] data_n;
  logic valid_n, last_n, pop, full, empty, hs;
  logic [DW+2:0] dout;
  assign hs = link.out_valid && link.out_ready;
  iot_sync_fifo #(.W(DW + 3), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(res_valid), .pop(pop), .din({fn_sel, res_data}),
    .dout(dout), .full(full), .empty(empty), .cnt(fifo_cnt)
  );
  // frame sequencing: pop in IDLE, hold bytes stable while stalled
  always_comb begin
    state_n = state;
    shreg_n = shreg;
    bcnt_n = bcnt;
    valid_n = link.out_valid;
    data_n = link.out_data;
    last_n = link.out_last;
    pop = 1'b0;
    unique case (state)
      IDLE: if (!empty) begin
        pop = 1'b1;
        shreg_n = dout[DW-1:0];
        bcnt_n = '0;
        state_n = HDR;
        valid_n = 1'b1;
        data_n = BW'({HDR_SYNC, dout[DW+2:DW]});
      end
      HDR: if (hs) begin
        data_n = shreg[DW-1 -: BW];
        state_n = DATA;
      end
      DATA: if (hs) begin
        if (link.out_last) begin
          state_n = IDLE;
          valid_n = 1'b0;
          data_n = '0;
          last_n = 1'b0;
        end else begin
          shreg_n = shreg << BW;
          bcnt_n = bcnt + CW'(1);
          data_n = shreg[DW-BW-1 -: BW];
          last_n = bcnt + CW'(1) == CW'(NB - 1);
        end
      end
      default: state_n = IDLE;
    endcase
  end
  // registered state and outputs; overflow sticks until reset
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
      bcnt <= '0;
      link.out_valid <= 1'b0;
      link.out_data <= '0;
      link.out_last <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_n;
      shreg <= shreg_n;
      bcnt <= bcnt_n;
      link.out_valid <= valid_n;
      link.out_data <= data_n;
      link.out_last <= last_n;
      overflow <= overflow | (res_valid && full && !pop);
    end
endmodule

// File: tb/tb_iot_result_serializer.sv
// tb_iot_result_serializer: table-driven frames plus hand sequences, scoreboard of expected bytes
module tb_iot_result_serializer;
  import iot_pkg::*;
  typedef struct {
    logic [2:0] fn;
    logic [127:0] data;
    logic [7:0] hdr;
    bit rnd;
  } vec_t;
  typedef struct {
    logic [8:0] b;
    int cyc;
  } rx_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic res_valid = 1'b0;
  logic [127:0] res_data = '0;
  logic [2:0] fn_sel = '0;
  logic overflow;
  logic [2:0] fifo_cnt;
  iot_result_serializer_if #(.BW(8)) link();
  iot_result_serializer #(.DEPTH(4), .DW(128), .BW(8)) dut (
    .clk(clk), .rst(rst), .res_valid(res_valid), .res_data(res_data), .fn_sel(fn_sel),
    .link(link), .overflow(overflow), .fifo_cnt(fifo_cnt)
  );
  always #5 clk = ~clk;
  int vec_n = 0, err_n = 0, cyc = 0, stall_viol = 0;
  int first_cyc, last_cyc;
  bit rnd_ready = 1'b0;
  logic prev_stall = 1'b0;
  logic [8:0] prev_b = '0;
  logic [8:0] exp_q[$];
  rx_t rx_q[$];
  vec_t vecs[5];
  always @(posedge clk) cyc <= cyc + 1;
  // monitor: collect accepted bytes, flag any change during a stall
  always @(negedge clk) begin
    if (prev_stall && !rst && (link.out_valid !== 1'b1 || {link.out_last, link.out_data} !== prev_b))
      stall_viol <= stall_viol + 1;
    prev_stall <= link.out_valid === 1'b1 && link.out_ready === 1'b0 && !rst;
    prev_b <= {link.out_last, link.out_data};
    if (link.out_valid === 1'b1 && link.out_ready === 1'b1 && !rst)
      rx_q.push_back('{b: {link.out_last, link.out_data}, cyc: cyc});
  end
  task automatic check(string nm, logic [63:0] act, logic [63:0] req);
    vec_n++;
    if (act !== req) begin
      err_n++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask
  task automatic push_frame(logic [2:0] fn, logic [127:0] d, logic [7:0] hdr);
    exp_q.push_back({1'b0, hdr});
    for (int i = 0; i < 16; i++) exp_q.push_back({1'(i == 15), d[127-8*i -: 8]});
  endtask
  task automatic cmp_rx();
    rx_t r;
    first_cyc = -1;
    while (rx_q.size() > 0) begin
      r = rx_q.pop_front();
      if (first_cyc < 0) first_cyc = r.cyc;
      last_cyc = r.cyc;
      if (exp_q.size() == 0) begin
        vec_n++;
        err_n++;
        $display("FAIL unexpected byte: got %0h, expected none", r.b);
      end else check("frame byte {last,data}", r.b, exp_q.pop_front());
    end
  endtask
  task automatic drain(int n);
    int budget = 3000;
    while (rx_q.size() < n && budget > 0) begin
      @(posedge clk);
      #1;
      link.out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      budget--;
    end
    if (rx_q.size() < n) begin
      vec_n++;
      err_n++;
      $display("FAIL drain timeout: got %0d bytes, expected %0d", rx_q.size(), n);
    end
    cmp_rx();
  endtask
  task automatic pulse(logic [2:0] fn, logic [127:0] d);
    @(posedge clk);
    #1;
    res_valid = 1'b1;
    fn_sel = fn;
    res_data = d;
    @(posedge clk);
    #1;
    res_valid = 1'b0;
    fn_sel = 3'($urandom);
    res_data = {4{$urandom}};
  endtask
  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    rx_q.delete();
    exp_q.delete();
  endtask
  initial begin
    int seen;
    link.out_ready = 1'b1;
    vecs[0] = '{FN_AVG, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 8'hA3, 1'b0};
    vecs[1] = '{FN_AVG, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 8'hA3, 1'b1};
    vecs[2] = '{FN_MAX, {128{1'b1}}, 8'hA1, 1'b0};
    vecs[3] = '{FN_PEAKMIN, 128'h8000_0000_0000_0000_0000_0000_0000_0001, 8'hA7, 1'b1};
    vecs[4] = '{FN_THRESH, 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555, 8'hA5, 1'b0};
    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", link.out_valid, 0);
    check("reset out_data", link.out_data, 0);
    check("reset out_last", link.out_last, 0);
    check("reset overflow", overflow, 0);
    check("reset fifo_cnt", fifo_cnt, 0);
    rst = 1'b0;
    for (int v = 0; v < 5; v++) begin
      rnd_ready = vecs[v].rnd;
      link.out_ready = 1'b1;
      push_frame(vecs[v].fn, vecs[v].data, vecs[v].hdr);
      pulse(vecs[v].fn, vecs[v].data);
      check("entry after push", fifo_cnt, 1);
      check("idle before header", link.out_valid, 0);
      @(posedge clk);
      #1;
      check("header valid", link.out_valid, 1);
      check("header byte", link.out_data, vecs[v].hdr);
      drain(17);
      if (!vecs[v].rnd) check("17 consecutive transfers", last_cyc - first_cyc, 16);
    end
    rnd_ready = 1'b0;
    link.out_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      if (k <= 5) push_frame(FN_SUM, 128'(k), 8'hA4);
      pulse(FN_SUM, 128'(k));
      check("fill fifo_cnt", fifo_cnt, k == 1 ? 1 : (k > 5 ? 4 : k - 1));
      check("fill overflow", overflow, k == 6);
    end
    drain(85);
    check("overflow sticky", overflow, 1);
    check("fifo empty after frames", fifo_cnt, 0);
    do_reset();
    check("overflow cleared by reset", overflow, 0);
    link.out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      push_frame(FN_MIN, 128'h100 + 128'(k), 8'hA2);
      pulse(FN_MIN, 128'h100 + 128'(k));
    end
    check("full fifo_cnt", fifo_cnt, 4);
    link.out_ready = 1'b1;
    seen = 0;
    for (int t = 0; t < 100 && !seen; t++) begin
      @(posedge clk);
      #1;
      seen = int'(link.out_last);
    end
    check("last byte reached", seen, 1);
    @(posedge clk);
    #1;
    check("idle between frames", link.out_valid, 0);
    res_valid = 1'b1;
    fn_sel = FN_PEAK;
    res_data = 128'hCAFE;
    push_frame(FN_PEAK, 128'hCAFE, 8'hA6);
    @(posedge clk);
    #1;
    res_valid = 1'b0;
    check("push+pop when full cnt", fifo_cnt, 4);
    check("push+pop when full overflow", overflow, 0);
    check("next header after bubble", link.out_valid, 1);
    drain(102);
    do_reset();
    link.out_ready = 1'b1;
    push_frame(FN_AVG, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 8'hA3);
    pulse(FN_AVG, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
    for (int t = 0; t < 100 && rx_q.size() < 8; t++) @(posedge clk);
    check("bytes before reset", rx_q.size(), 8);
    #3;
    rst = 1'b1;
    #1;
    check("async rst out_valid", link.out_valid, 0);
    check("async rst out_data", link.out_data, 0);
    check("async rst out_last", link.out_last, 0);
    check("async rst fifo_cnt", fifo_cnt, 0);
    cmp_rx();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    seen = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      seen += int'(link.out_valid);
    end
    check("no resumption after reset", seen, 0);
    push_frame(FN_MAX, 128'hA0A1_A2A3_A4A5_A6A7_A8A9_AAAB_ACAD_AEAF, 8'hA1);
    pulse(FN_MAX, 128'hA0A1_A2A3_A4A5_A6A7_A8A9_AAAB_ACAD_AEAF);
    repeat (130) @(posedge clk);
    push_frame(FN_SUM, 128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100, 8'hA4);
    pulse(FN_SUM, 128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100);
    repeat (5) @(posedge clk);
    push_frame(FN_PEAKMIN, 128'h5555_AAAA_5555_AAAA_5555_AAAA_5555_AAAA, 8'hA7);
    pulse(FN_PEAKMIN, 128'h5555_AAAA_5555_AAAA_5555_AAAA_5555_AAAA);
    drain(51);
    repeat (20) @(posedge clk);
    cmp_rx();
    check("stall stability violations", stall_viol, 0);
    check("expected bytes left over", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_n, err_n);
    $finish;
  end
endmodule
